// File: rtl/kong_pkg.sv
// Shared types and constants for the Kong hit manager: FSM state encoding,
// point values (BCD) and the saturation ceiling for the 4-digit score.
package kong_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_PLAY      = 3'd1,
        ST_DYING     = 3'd2,
        ST_GAME_OVER = 3'd3,
        ST_WIN       = 3'd4
    } state_t;

    // Point values in BCD, hundreds digit only
    localparam logic [11:0] PTS_BARREL_JUMP = 12'h100;
    localparam logic [11:0] PTS_BONUS_ITEM  = 12'h300;

    localparam logic [15:0] BCD_MAX = 16'h9999;

endpackage

// File: rtl/bcd_score_adder.sv
// Combinational 4-digit BCD adder: 16-bit BCD score plus 12-bit BCD increment.
// A carry out of the thousands digit saturates the sum at 9999 and raises
// carry_out.
module bcd_score_adder
    import kong_pkg::*;
(
    input  logic [15:0] score_in,
    input  logic [11:0] inc_in,
    output logic [15:0] sum_out,
    output logic        carry_out
);

    logic [15:0] inc_ext;
    logic [15:0] raw;
    logic [4:0]  dig;
    logic        c;

    // Ripple the decimal carry digit by digit, then clamp on overflow
    always_comb begin
        inc_ext = {4'h0, inc_in};
        raw     = '0;
        dig     = '0;
        c       = 1'b0;
        for (int i = 0; i < 4; i++) begin
            dig = {1'b0, score_in[4*i +: 4]} + {1'b0, inc_ext[4*i +: 4]} + {4'b0, c};
            if (dig > 5'd9) begin
                raw[4*i +: 4] = 4'(dig - 5'd10);
                c             = 1'b1;
            end else begin
                raw[4*i +: 4] = dig[3:0];
                c             = 1'b0;
            end
        end
        carry_out = c;
        sum_out   = c ? BCD_MAX : raw;
    end

endmodule

// File: rtl/kong_hit_manager.sv
// Game-flow controller: turns per-frame collision pulses into score, lives
// and the IDLE/PLAY/DYING/GAME_OVER/WIN state machine. All outputs are
// registered, so a pulse in cycle n shows up in cycle n+1.
// Optional feature: define HIT_MANAGER_BONUS_LIFE_EN to award one extra life
// (capped at 7) the first time the score crosses 1000 in a game.
module kong_hit_manager
    import kong_pkg::*;
#(
    parameter int INITIAL_LIVES = 3,
    parameter int DEATH_FRAMES  = 60,
    parameter int INVULN_FRAMES = 90
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        startOfFrame,
    input  logic        start_game,
    input  logic        SingleHitPulse1,
    input  logic        SingleHitPulse2,
    input  logic        SingleHitPulse3,
    input  logic        SingleHitPulse4,
    output logic [2:0]  game_state,
    output logic [15:0] score_bcd,
    output logic [2:0]  lives,
    output logic        kong_freeze,
    output logic        kong_blink,
    output logic        level_restart
);

    localparam int FW = (DEATH_FRAMES  > 0) ? $clog2(DEATH_FRAMES + 1)  : 1;
    localparam int IW = (INVULN_FRAMES > 0) ? $clog2(INVULN_FRAMES + 1) : 1;

    state_t         state;
    logic [FW-1:0]  frame_cnt, frame_dec;
    logic [IW-1:0]  inv_cnt, inv_dec;
    logic [11:0]    add_amt;
    logic [15:0]    add_sum, score_nxt;
    logic           add_ovf;
    logic           die_hit;
    logic [3:0]     lives_calc;
    logic [2:0]     lives_play;

    assign game_state = state;

    bcd_score_adder u_adder (
        .score_in  (score_bcd),
        .inc_in    (add_amt),
        .sum_out   (add_sum),
        .carry_out (add_ovf)
    );

    // Per-cycle next values: frame-paced countdowns, score increment, death test
    always_comb begin
        frame_dec = (startOfFrame && frame_cnt != '0) ? frame_cnt - FW'(1) : frame_cnt;
        inv_dec   = (startOfFrame && inv_cnt   != '0) ? inv_cnt   - IW'(1) : inv_cnt;
        // Both constants only use the hundreds digit, so a binary sum stays valid BCD
        add_amt   = (SingleHitPulse2 ? PTS_BARREL_JUMP : 12'h000)
                  + (SingleHitPulse3 ? PTS_BONUS_ITEM  : 12'h000);
        score_nxt = add_ovf ? BCD_MAX : add_sum;
        // Win outranks death; invulnerability masks barrel hits
        die_hit   = SingleHitPulse1 && !SingleHitPulse4 && (inv_cnt == '0);
        // Lives are >= 1 in PLAY, so a death never underflows here
        lives_play = (lives_calc > 4'd7) ? 3'd7 : lives_calc[2:0];
    end

`ifdef HIT_MANAGER_BONUS_LIFE_EN
    logic bonus_used;
    logic bonus_hit;

    assign bonus_hit  = (state == ST_PLAY) && !bonus_used
                     && (score_bcd[15:12] == 4'h0) && (score_nxt[15:12] != 4'h0);
    assign lives_calc = {1'b0, lives} + {3'b0, bonus_hit} - {3'b0, die_hit};

    // One bonus life per game: armed at game start, spent on the first 1000 crossing
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            bonus_used <= 1'b0;
        else if (start_game && (state == ST_IDLE || state == ST_GAME_OVER || state == ST_WIN))
            bonus_used <= 1'b0;
        else if (bonus_hit)
            bonus_used <= 1'b1;
    end
`else
    assign lives_calc = {1'b0, lives} - {3'b0, die_hit};
`endif

    // Game FSM with registered score, lives, counters and status outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= ST_IDLE;
            score_bcd     <= '0;
            lives         <= 3'(INITIAL_LIVES);
            frame_cnt     <= '0;
            inv_cnt       <= '0;
            kong_freeze   <= 1'b1;
            kong_blink    <= 1'b0;
            level_restart <= 1'b0;
        end else begin
            level_restart <= 1'b0;
            frame_cnt     <= frame_dec;
            inv_cnt       <= inv_dec;
            kong_blink    <= (inv_dec != '0);
            case (state)
                ST_IDLE, ST_GAME_OVER, ST_WIN: begin
                    if (start_game) begin
                        state         <= ST_PLAY;
                        score_bcd     <= '0;
                        lives         <= 3'(INITIAL_LIVES);
                        frame_cnt     <= '0;
                        inv_cnt       <= '0;
                        kong_blink    <= 1'b0;
                        kong_freeze   <= 1'b0;
                        level_restart <= 1'b1;
                    end
                end
                ST_PLAY: begin
                    score_bcd <= score_nxt;
                    lives     <= lives_play;
                    if (SingleHitPulse4) begin
                        state       <= ST_WIN;
                        kong_freeze <= 1'b1;
                    end else if (die_hit) begin
                        state       <= ST_DYING;
                        kong_freeze <= 1'b1;
                        frame_cnt   <= FW'(DEATH_FRAMES);
                    end
                end
                ST_DYING: begin
                    if (frame_cnt == '0) begin
                        if (lives == 3'd0) begin
                            state <= ST_GAME_OVER;
                        end else begin
                            state         <= ST_PLAY;
                            kong_freeze   <= 1'b0;
                            level_restart <= 1'b1;
                            inv_cnt       <= IW'(INVULN_FRAMES);
                            kong_blink    <= (INVULN_FRAMES != 0);
                        end
                    end
                end
                default: begin
                    state       <= ST_IDLE;
                    kong_freeze <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_kong_hit_manager.sv
// Bench for kong_hit_manager: directed game scenarios followed by random
// pulses, every cycle compared against an integer-level game model.
module tb_kong_hit_manager;
    import kong_pkg::*;

    localparam int INIT_L  = 3;
    localparam int DEATH_F = 60;
    localparam int INV_F   = 90;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        sof = 1'b0, sg = 1'b0;
    logic        p1 = 1'b0, p2 = 1'b0, p3 = 1'b0, p4 = 1'b0;
    logic [2:0]  game_state;
    logic [15:0] score_bcd;
    logic [2:0]  lives;
    logic        kong_freeze, kong_blink, level_restart;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: plain integers, decimal score
    state_t m_state;
    int     m_score, m_lives, m_frame, m_inv, m_restart, m_bonus;

    kong_hit_manager #(
        .INITIAL_LIVES (INIT_L),
        .DEATH_FRAMES  (DEATH_F),
        .INVULN_FRAMES (INV_F)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .startOfFrame    (sof),
        .start_game      (sg),
        .SingleHitPulse1 (p1),
        .SingleHitPulse2 (p2),
        .SingleHitPulse3 (p3),
        .SingleHitPulse4 (p4),
        .game_state      (game_state),
        .score_bcd       (score_bcd),
        .lives           (lives),
        .kong_freeze     (kong_freeze),
        .kong_blink      (kong_blink),
        .level_restart   (level_restart)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string where);
        chk({where, ":state"},   {13'b0, game_state},   {13'b0, m_state});
        chk({where, ":score"},   score_bcd,             to_bcd(m_score));
        chk({where, ":lives"},   {13'b0, lives},        16'(m_lives));
        chk({where, ":freeze"},  {15'b0, kong_freeze},  {15'b0, m_state != ST_PLAY});
        chk({where, ":blink"},   {15'b0, kong_blink},   {15'b0, m_inv != 0});
        chk({where, ":restart"}, {15'b0, level_restart}, 16'(m_restart));
    endtask

    task automatic model_reset();
        m_state = ST_IDLE; m_score = 0; m_lives = INIT_L;
        m_frame = 0; m_inv = 0; m_restart = 0; m_bonus = 0;
    endtask

    task automatic model_step(input bit s, input bit g, input bit h1, input bit h2,
                              input bit h3, input bit h4);
        int f_old, i_old, old_sc, b, d;
        f_old = m_frame; i_old = m_inv; b = 0; d = 0;
        m_restart = 0;
        if (s && m_frame > 0) m_frame--;
        if (s && m_inv > 0)   m_inv--;
        case (m_state)
            ST_IDLE, ST_GAME_OVER, ST_WIN: begin
                if (g) begin
                    m_state = ST_PLAY; m_score = 0; m_lives = INIT_L;
                    m_frame = 0; m_inv = 0; m_restart = 1; m_bonus = 0;
                end
            end
            ST_PLAY: begin
                old_sc  = m_score;
                m_score = m_score + (h2 ? 100 : 0) + (h3 ? 300 : 0);
                if (m_score > 9999) m_score = 9999;
`ifdef HIT_MANAGER_BONUS_LIFE_EN
                if (m_bonus == 0 && old_sc < 1000 && m_score >= 1000) begin
                    b = 1; m_bonus = 1;
                end
`endif
                d = (h1 && !h4 && i_old == 0) ? 1 : 0;
                m_lives = m_lives + b - d;
                if (m_lives > 7) m_lives = 7;
                if (h4) m_state = ST_WIN;
                else if (d == 1) begin
                    m_state = ST_DYING; m_frame = DEATH_F;
                end
            end
            ST_DYING: begin
                if (f_old == 0) begin
                    if (m_lives == 0) m_state = ST_GAME_OVER;
                    else begin
                        m_state = ST_PLAY; m_restart = 1; m_inv = INV_F;
                    end
                end
            end
            default: ;
        endcase
    endtask

    // One clock: drive, update model on the edge, compare 1 time unit later
    task automatic step(input string where, input bit s, input bit g, input bit h1,
                        input bit h2, input bit h3, input bit h4);
        sof = s; sg = g; p1 = h1; p2 = h2; p3 = h3; p4 = h4;
        @(posedge clk);
        model_step(s, g, h1, h2, h3, h4);
        #1;
        sof = 0; sg = 0; p1 = 0; p2 = 0; p3 = 0; p4 = 0;
        check_all(where);
    endtask

    task automatic do_reset(input string where);
        reset = 1'b1;
        #1;
        model_reset();
        check_all({where, ":async"});
        @(posedge clk);
        #1;
        reset = 1'b0;
        check_all({where, ":held"});
    endtask

    task automatic frames(input string where, input int n);
        for (int i = 0; i < n; i++) step(where, 1, 0, 0, 0, 0, 0);
    endtask

    initial begin
        @(posedge clk); #1;
        do_reset("reset");
        chk("reset_lives", {13'b0, lives}, 16'd3);

        step("idle_hits", 0, 0, 1, 1, 1, 1);
        step("start", 0, 1, 0, 0, 0, 0);
        chk("start_restart", {15'b0, level_restart}, 16'd1);
        step("start_in_play", 0, 1, 0, 0, 0, 0);

        step("add400", 0, 0, 0, 1, 1, 0);
        chk("add400_val", score_bcd, 16'h0400);
        for (int i = 0; i < 23; i++) step("climb", 0, 0, 0, 1, 1, 0);
        step("to9900", 0, 0, 0, 0, 1, 0);
        chk("at9900", score_bcd, 16'h9900);
        step("sat", 0, 0, 0, 0, 1, 0);
        chk("sat_val", score_bcd, 16'h9999);
        step("sat_hold", 0, 0, 0, 1, 0, 0);

        step("die", 0, 0, 1, 0, 0, 0);
        chk("die_state", {13'b0, game_state}, {13'b0, ST_DYING});
        step("dying_ignored", 0, 1, 1, 1, 1, 0);
        frames("dying", DEATH_F + 1);
        chk("respawn_blink", {15'b0, kong_blink}, 16'd1);
        frames("invuln", 10);
        step("invuln_hit", 0, 0, 1, 0, 0, 0);
        chk("invuln_state", {13'b0, game_state}, {13'b0, ST_PLAY});
        frames("invuln_end", INV_F - 8);

        step("win_over_death", 0, 0, 1, 0, 0, 1);
        chk("win_state", {13'b0, game_state}, {13'b0, ST_WIN});

        step("restart", 0, 1, 0, 0, 0, 0);
        for (int k = 0; k < INIT_L; k++) begin
            step("die_n", 0, 0, 1, 0, 0, 0);
            frames("dying_n", DEATH_F + 1);
            if (k < INIT_L - 1) frames("inv_n", INV_F + 1);
        end
        chk("game_over", {13'b0, game_state}, {13'b0, ST_GAME_OVER});

        // Bonus threshold walk: 0900 then +100
        step("restart2", 0, 1, 0, 0, 0, 0);
        step("b1", 0, 0, 0, 1, 1, 0);
        step("b2", 0, 0, 0, 1, 1, 0);
        step("b3", 0, 0, 0, 1, 0, 0);
        step("cross1000", 0, 0, 0, 1, 0, 0);
        step("past1000", 0, 0, 0, 1, 1, 0);

        // Abort mid-DYING: no respawn pulse may leak out afterwards
        step("die_abort", 0, 0, 1, 0, 0, 0);
        frames("dying_abort", 5);
        do_reset("reset_mid");
        frames("post_reset", 5);

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(399) == 0) do_reset("rnd_reset");
            step("rnd",
                 1'($urandom_range(1)),
                 $urandom_range(39) == 0,
                 $urandom_range(24) == 0,
                 $urandom_range(5) == 0,
                 $urandom_range(9) == 0,
                 $urandom_range(149) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/kong_hit_manager.md
KONG_HIT_MANAGER -- requirements
Module: kong_hit_manager

Interface
REQ-001 SHALL have parameter INITIAL_LIVES, default 3, lives loaded at game start (range 1..7).
REQ-002 SHALL have parameter DEATH_FRAMES, default 60, frames spent in DYING.
REQ-003 SHALL have parameter INVULN_FRAMES, default 90, frames of post-respawn death immunity.
REQ-004 SHALL have port clk, input, 1 bit, single clock; all logic is posedge clk.
REQ-005 SHALL have port reset, input, 1 bit, asynchronous active-high reset.
REQ-006 SHALL have port startOfFrame, input, 1 bit, one-cycle pulse per video frame.
REQ-007 SHALL have port start_game, input, 1 bit, one-cycle pulse from the start key.
REQ-008 SHALL have ports SingleHitPulse1..4, input, 1 bit each, one-cycle-per-frame collision pulses: 1 = barrel (death), 2 = barrel jumped (+100), 3 = bonus item (+300), 4 = princess reached (win).
REQ-009 SHALL have port game_state, output, 3 bits, encoded current FSM state.
REQ-010 SHALL have port score_bcd, output, 16 bits, 4-digit BCD score.
REQ-011 SHALL have port lives, output, 3 bits, remaining lives.
REQ-012 SHALL have port kong_freeze, output, 1 bit, high in every state except PLAY.
REQ-013 SHALL have port kong_blink, output, 1 bit, high while the invulnerability counter is nonzero.
REQ-014 SHALL have port level_restart, output, 1 bit, one-cycle pulse to reposition sprites.

Function
REQ-015 SHALL implement states IDLE, PLAY, DYING, GAME_OVER, WIN.
REQ-016 IDLE/GAME_OVER/WIN + start_game SHALL go to PLAY: score cleared, lives = INITIAL_LIVES, invuln = 0, level_restart pulsed.
REQ-017 Hit pulses SHALL be ignored outside PLAY.
REQ-018 PLAY + pulse4 SHALL go to WIN; it overrides pulse1 in the same cycle, and score pulses in that cycle still add.
REQ-019 PLAY + pulse1 with invuln = 0 and no pulse4 SHALL go to DYING, decrement lives, and load the frame counter with DEATH_FRAMES.
REQ-020 pulse1 with invuln != 0 SHALL be ignored.
REQ-021 pulse2 and pulse3 SHALL add +100/+300; simultaneous pulses SHALL add +400 in one cycle.
REQ-022 Score addition SHALL be BCD and saturate at 9999; no wrap-around.
REQ-023 Frame and invuln counters SHALL decrement only on startOfFrame and SHALL not go below 0.
REQ-024 DYING with counter = 0 SHALL go to GAME_OVER if lives = 0; otherwise it SHALL pulse level_restart, load invuln with INVULN_FRAMES, and go to PLAY.
REQ-025 All outputs SHALL be registered; a pulse at cycle n SHALL be visible at cycle n+1.
REQ-026 start_game in PLAY or DYING SHALL be ignored.

Reset
REQ-027 reset SHALL force IDLE, score_bcd = 0, lives = INITIAL_LIVES, counters = 0, kong_freeze = 1, kong_blink = 0, level_restart = 0.
REQ-028 reset asserted mid-DYING or mid-addition SHALL abort immediately, with no pending pulse emitted after release.

Configuration
REQ-029 Macro HIT_MANAGER_BONUS_LIFE_EN defined: the first score crossing from <1000 to >=1000 in a game SHALL add one life (max 7), once per game.
REQ-030 Macro undefined: no bonus-life logic SHALL be present, and lives SHALL change only per REQ-016/019.

Structure
REQ-031 Package kong_pkg SHALL hold the state enum, point constants (100, 300), and the BCD max constant 16'h9999.
REQ-032 Sub-module bcd_score_adder SHALL be combinational: 16-bit BCD plus 12-bit BCD increment, saturating, with a carry-out flag.

Verification
REQ-033 Reset, then start_game -> PLAY, lives 3, score 0000, one level_restart pulse.
REQ-034 PLAY, pulse2 and pulse3 in the same cycle -> score_bcd 0400 next cycle; from 9900, pulse3 -> 9999.
REQ-035 PLAY, pulse1 -> DYING, lives 2, kong_freeze = 1; after 60 startOfFrame -> PLAY, level_restart pulse, kong_blink = 1 for 90 frames.
REQ-036 pulse1 during the invulnerability window -> no state change; lives unchanged.
REQ-037 pulse1 and pulse4 in the same cycle -> WIN, lives unchanged; with lives 1, pulse1 followed by 60 frames -> GAME_OVER.
REQ-038 With HIT_MANAGER_BONUS_LIFE_EN, score 0900 + pulse2 -> 1000, lives +1; a second crossing -> no change.
